// File: rtl/split_arbiter.sv
// split_arbiter: two-master / three-slave bus arbiter with split (park/resume) support.
// Optional watchdog forced release is built only when SPLIT_ARB_TIMEOUT_EN is defined.
module split_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m1_request,
  input  logic       m2_request,
  input  logic [1:0] m1_slave_sel,
  input  logic [1:0] m2_slave_sel,
  input  logic       trans_done,
  input  logic       s1_split_en,
  input  logic       s2_split_en,
  input  logic       s3_split_en,
  output logic       m1_grant,
  output logic       m2_grant,
  output logic       arbiter_busy,
  output logic       bus_busy,
  output logic       mux_master,
  output logic [1:0] mux_slave,
  output logic       m1_parked,
  output logic       m2_parked,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_e;
  localparam logic [1:0] SEL_INVALID = 2'b11;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("split_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic       owner_q, owner_d;
  logic [1:0] slave_q, slave_d;
  logic       park1_q, park1_d, park2_q, park2_d;
  logic [1:0] pslave1_q, pslave1_d, pslave2_q, pslave2_d;
  logic       m1_grant_q, m1_grant_d, m2_grant_q, m2_grant_d;
  logic       abusy_q, abusy_d, bbusy_q, bbusy_d;
  logic       res1_s, res2_s, elig1_s, elig2_s, owner_req_s, own_split_s, timeout_s;

  function automatic logic split_of(input logic [1:0] sel, input logic sp1,
                                    input logic sp2, input logic sp3);
    case (sel)
      2'b00:   split_of = sp1;
      2'b01:   split_of = sp2;
      2'b10:   split_of = sp3;
      default: split_of = 1'b0;
    endcase
  endfunction

  assign res1_s = park1_q & ~split_of(pslave1_q, s1_split_en, s2_split_en, s3_split_en);
  assign res2_s = park2_q & ~split_of(pslave2_q, s1_split_en, s2_split_en, s3_split_en);
  // A new request is blocked if invalid, already parked, or aimed at the other master's parked slave.
  assign elig1_s = m1_request & ~park1_q & (m1_slave_sel != SEL_INVALID) &
                   ~(park2_q & (pslave2_q == m1_slave_sel));
  assign elig2_s = m2_request & ~park2_q & (m2_slave_sel != SEL_INVALID) &
                   ~(park1_q & (pslave1_q == m2_slave_sel));
  assign owner_req_s = owner_q ? m2_request : m1_request;
  assign own_split_s = split_of(slave_q, s1_split_en, s2_split_en, s3_split_en);

`ifdef SPLIT_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        owner_parked_s;

  assign owner_parked_s = owner_q ? park2_q : park1_q;

  always_comb begin
    if (state_q == BUSY) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = (state_q == BUSY) && (cnt_q == TO_LAST) && !trans_done &&
                     !own_split_s && owner_req_s && !owner_parked_s;
`else
  assign timeout_s = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      owner_q    <= 1'b0;
      slave_q    <= 2'b00;
      park1_q    <= 1'b0;
      park2_q    <= 1'b0;
      pslave1_q  <= 2'b00;
      pslave2_q  <= 2'b00;
      m1_grant_q <= 1'b0;
      m2_grant_q <= 1'b0;
      abusy_q    <= 1'b0;
      bbusy_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      owner_q    <= owner_d;
      slave_q    <= slave_d;
      park1_q    <= park1_d;
      park2_q    <= park2_d;
      pslave1_q  <= pslave1_d;
      pslave2_q  <= pslave2_d;
      m1_grant_q <= m1_grant_d;
      m2_grant_q <= m2_grant_d;
      abusy_q    <= abusy_d;
      bbusy_q    <= bbusy_d;
    end
  end

  // ready_q holds off arbitration for the first edge after reset release.
  always_comb begin
    state_d   = state_q;
    ready_d   = 1'b1;
    owner_d   = owner_q;
    slave_d   = slave_q;
    park1_d   = park1_q;
    park2_d   = park2_q;
    pslave1_d = pslave1_q;
    pslave2_d = pslave2_q;
    case (state_q)
      IDLE: begin
        if (!ready_q) begin
          state_d = IDLE;
        end else if (res1_s) begin
          state_d = BUSY; owner_d = 1'b0; slave_d = pslave1_q; park1_d = 1'b0;
        end else if (res2_s) begin
          state_d = BUSY; owner_d = 1'b1; slave_d = pslave2_q; park2_d = 1'b0;
        end else if (elig1_s) begin
          state_d = BUSY; owner_d = 1'b0; slave_d = m1_slave_sel;
        end else if (elig2_s) begin
          state_d = BUSY; owner_d = 1'b1; slave_d = m2_slave_sel;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (trans_done) begin
          state_d = RELEASE;
        end else if (own_split_s) begin
          state_d = RELEASE;
          if (owner_q) begin
            park2_d = 1'b1; pslave2_d = slave_q;
          end else begin
            park1_d = 1'b1; pslave1_d = slave_q;
          end
        end else if (!owner_req_s || timeout_s) begin
          state_d = RELEASE;
        end else begin
          state_d = BUSY;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m1_grant_d = (state_d == BUSY) && !owner_d;
    m2_grant_d = (state_d == BUSY) && owner_d;
    abusy_d    = (state_d != IDLE);
    bbusy_d    = (state_d == BUSY);
  end

  assign m1_grant     = m1_grant_q;
  assign m2_grant     = m2_grant_q;
  assign arbiter_busy = abusy_q;
  assign bus_busy     = bbusy_q;
  assign mux_master   = owner_q;
  assign mux_slave    = slave_q;
  assign m1_parked    = park1_q;
  assign m2_parked    = park2_q;
  assign timeout      = timeout_s;

endmodule

// File: tb/tb_split_arbiter.sv
// Bench for split_arbiter: vector table through a scoreboard queue, then hand sequences
// for long ownership / forced release, asynchronous reset with a parked master, and invalid select.
module tb_split_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       m1_request, m2_request, trans_done;
  logic [1:0] m1_slave_sel, m2_slave_sel;
  logic       s1_split_en, s2_split_en, s3_split_en;
  logic       m1_grant, m2_grant, arbiter_busy, bus_busy, mux_master;
  logic [1:0] mux_slave;
  logic       m1_parked, m2_parked, timeout;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  typedef struct {
    logic       r1, r2;
    logic [1:0] sel1, sel2;
    logic       done;
    logic [2:0] sp;    // {s3,s2,s1}
    logic [8:0] expv;  // {m1g,m2g,abusy,bbusy,mux_master,mux_slave,m1_parked,m2_parked}
  } vec_t;

  localparam int NV = 38;
  vec_t tbl[NV];

  split_arbiter #(.TIMEOUT_CYCLES(500)) dut (
    .clk(clk), .rst(rst),
    .m1_request(m1_request), .m2_request(m2_request),
    .m1_slave_sel(m1_slave_sel), .m2_slave_sel(m2_slave_sel),
    .trans_done(trans_done),
    .s1_split_en(s1_split_en), .s2_split_en(s2_split_en), .s3_split_en(s3_split_en),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .arbiter_busy(arbiter_busy), .bus_busy(bus_busy),
    .mux_master(mux_master), .mux_slave(mux_slave),
    .m1_parked(m1_parked), .m2_parked(m2_parked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r1, input logic r2, input logic [1:0] s1,
                              input logic [1:0] s2, input logic d, input logic [2:0] sp,
                              input logic [8:0] e);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.sel1 = s1; v.sel2 = s2; v.done = d; v.sp = sp; v.expv = e;
    return v;
  endfunction

  function automatic int obs();
    return int'({m1_grant, m2_grant, arbiter_busy, bus_busy, mux_master, mux_slave,
                 m1_parked, m2_parked, timeout});
  endfunction

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, expv);
    end
  endtask

  task automatic drive(input logic r1, input logic r2, input logic [1:0] s1,
                       input logic [1:0] s2, input logic d, input logic [2:0] sp);
    m1_request = r1; m2_request = r2; m1_slave_sel = s1; m2_slave_sel = s2;
    trans_done = d; {s3_split_en, s2_split_en, s1_split_en} = sp;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int waited;
    int first_to;
    int cnt;

    tbl[0]  = mk(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000, 9'b0_0_0_0_0_00_0_0);
    tbl[1]  = mk(1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000, 9'b1_0_1_1_0_00_0_0);
    tbl[2]  = mk(1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 3'b000, 9'b0_0_1_0_0_00_0_0);
    tbl[3]  = mk(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000, 9'b0_0_0_0_0_00_0_0);
    tbl[4]  = mk(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000, 9'b0_1_1_1_1_01_0_0);
    tbl[5]  = mk(1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 3'b000, 9'b0_0_1_0_1_01_0_0);
    tbl[6]  = mk(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'b000, 9'b0_0_0_0_1_01_0_0);
    tbl[7]  = mk(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 3'b000, 9'b1_0_1_1_0_10_0_0);
    tbl[8]  = mk(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 3'b100, 9'b0_0_1_0_0_10_1_0);
    tbl[9]  = mk(1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 3'b100, 9'b0_0_0_0_0_10_1_0);
    tbl[10] = mk(1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 3'b100, 9'b0_0_0_0_0_10_1_0);
    tbl[11] = mk(1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 3'b100, 9'b0_0_0_0_0_10_1_0);
    tbl[12] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 3'b100, 9'b0_1_1_1_1_00_1_0);
    tbl[13] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_1_1_1_1_00_1_0);
    tbl[14] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_1_1_1_1_00_1_0);
    tbl[15] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 3'b000, 9'b0_0_1_0_1_00_1_0);
    tbl[16] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_0_0_0_1_00_1_0);
    tbl[17] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 3'b000, 9'b1_0_1_1_0_10_0_0);
    tbl[18] = mk(1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 3'b100, 9'b0_0_1_0_0_10_0_0);
    tbl[19] = mk(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_0_0_0_0_10_0_0);
    tbl[20] = mk(1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_1_1_1_1_00_0_0);
    tbl[21] = mk(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_0_1_0_1_00_0_0);
    tbl[22] = mk(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 3'b000, 9'b0_0_0_0_1_00_0_0);
    tbl[23] = mk(1'b0, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 9'b0_0_0_0_1_00_0_0);
    tbl[24] = mk(1'b0, 1'b1, 2'b10, 2'b11, 1'b0, 3'b000, 9'b0_0_0_0_1_00_0_0);
    tbl[25] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b000, 9'b1_0_1_1_0_01_0_0);
    tbl[26] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b010, 9'b0_0_1_0_0_01_1_0);
    tbl[27] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b010, 9'b0_0_0_0_0_01_1_0);
    tbl[28] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b010, 9'b0_1_1_1_1_10_1_0);
    tbl[29] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b110, 9'b0_0_1_0_1_10_1_1);
    tbl[30] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b110, 9'b0_0_0_0_1_10_1_1);
    tbl[31] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b110, 9'b0_0_0_0_1_10_1_1);
    tbl[32] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 3'b100, 9'b1_0_1_1_0_01_0_1);
    tbl[33] = mk(1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 3'b100, 9'b0_0_1_0_0_01_0_1);
    tbl[34] = mk(1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 3'b000, 9'b0_0_0_0_0_01_0_1);
    tbl[35] = mk(1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 3'b000, 9'b0_1_1_1_1_10_0_0);
    tbl[36] = mk(1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 3'b000, 9'b0_0_1_0_1_10_0_0);
    tbl[37] = mk(1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 3'b000, 9'b0_0_0_0_1_10_0_0);

    rst = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", obs(), 0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].r1, tbl[i].r2, tbl[i].sel1, tbl[i].sel2, tbl[i].done, tbl[i].sp);
      exp_q.push_back(int'({tbl[i].expv, 1'b0}));
      tick();
      check($sformatf("vec%0d", i), obs(), exp_q.pop_front());
    end

    // Long ownership by M2 on S2: forced release with the watchdog, otherwise held indefinitely.
    drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 3'b000);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!m2_grant && waited < 8);
    check("hold_grant_seen", int'(m2_grant), 1);
`ifdef SPLIT_ARB_TIMEOUT_EN
    first_to = 0;
    for (int n = 1; n <= 600; n++) begin
      if (timeout) begin
        first_to = n;
        break;
      end
      tick();
    end
    check("timeout_cycle", first_to, 500);
    drive(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'b000);
`else
    cnt = 0;
    first_to = 0;
    for (int n = 0; n < 1000; n++) begin
      if (m2_grant) cnt++;
      if (timeout) first_to++;
      tick();
    end
    check("hold_1000_cycles", cnt, 1000);
    check("no_timeout_pulse", first_to, 0);
    drive(1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 3'b000);
`endif
    tick();
    check("hold_release", obs(), int'(10'b0_0_1_0_1_01_0_0_0));
    drive(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'b000);
    tick();
    check("hold_idle", obs(), int'(10'b0_0_0_0_1_01_0_0_0));

    // M1 parks on S3, M2 owns S1, then asynchronous reset mid-cycle.
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 3'b000);
    tick();
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 3'b100);
    tick();
    drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 3'b100);
    tick();
    tick();
    check("pre_reset_parked_busy", obs(), int'(10'b0_1_1_1_1_00_1_0_0));
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_outputs", obs(), 0);
    @(negedge clk);
    check("reset_held_outputs", obs(), 0);
    rst = 1'b1;

    // Invalid slave select must never be granted.
    drive(1'b0, 1'b1, 2'b00, 2'b11, 1'b0, 3'b000);
    cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (m2_grant || m1_grant || arbiter_busy) cnt++;
    end
    check("sel11_never_granted", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
